// File: rtl/pim_tile_scheduler.sv
// Tile scheduler for one C = A x B multiply: hands each PIM unit its K k-step jobs
// over a valid/ready handshake and reports done once every unit has finished.
module pim_tile_scheduler #(
  parameter int NUM_UNITS   = 4,
  parameter int GRID        = 2,
  parameter int MATRIX_SIZE = 16,
  parameter int CHUNK_SIZE  = 8,
  parameter int LEN         = 10,
  parameter int A_BASE      = 0,
  parameter int B_BASE      = 256,
  parameter int C_BASE      = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [31:0]              cycles,
  output logic [NUM_UNITS-1:0]     job_valid,
  input  logic [NUM_UNITS-1:0]     job_ready,
  output logic [NUM_UNITS*LEN-1:0] job_a_addr,
  output logic [NUM_UNITS*LEN-1:0] job_b_addr,
  output logic [NUM_UNITS*LEN-1:0] job_c_addr,
  output logic [NUM_UNITS-1:0]     job_accum,
  input  logic [NUM_UNITS-1:0]     unit_done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | offering jobs / waiting for unit completions
  // FIN   | one-cycle done pulse

  localparam int K  = MATRIX_SIZE / CHUNK_SIZE;
  localparam int KW = $clog2(K + 1);
  localparam logic [KW-1:0] K_L = KW'(K);
  localparam int ROW_STRIDE = CHUNK_SIZE * MATRIX_SIZE;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q [NUM_UNITS];
  logic [KW-1:0]          k_d [NUM_UNITS];
  logic [NUM_UNITS-1:0]   out_q, out_d;
  logic [NUM_UNITS-1:0]   xfer, spurious;
  logic                   err_q;
  logic [31:0]            cycles_q;
  logic                   start_acc, abort_acc, all_fin;

  assign start_acc = (state_q == IDLE) && start;
  assign abort_acc = (state_q == RUN) && abort;
  assign xfer      = job_valid & job_ready;
  assign spurious  = unit_done & ~out_q;

  // Payload is derived from the unit's k, which cannot move while the offer is pending.
  always_comb begin
    int r_v, c_v, k_v;
    logic vld;
    job_valid  = '0;
    job_accum  = '0;
    job_a_addr = '0;
    job_b_addr = '0;
    job_c_addr = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      r_v = u / GRID;
      c_v = u % GRID;
      k_v = int'(k_q[u]);
      vld = (state_q == RUN) && (k_q[u] < K_L) && !out_q[u];
      job_valid[u] = vld;
      if (vld) begin
        job_a_addr[u*LEN +: LEN] = LEN'(A_BASE + r_v*ROW_STRIDE + k_v*CHUNK_SIZE);
        job_b_addr[u*LEN +: LEN] = LEN'(B_BASE + k_v*ROW_STRIDE + c_v*CHUNK_SIZE);
        job_c_addr[u*LEN +: LEN] = LEN'(C_BASE + r_v*ROW_STRIDE + c_v*CHUNK_SIZE);
        job_accum[u]             = (k_q[u] != '0);
      end
    end
  end

  always_comb begin
    k_d     = k_q;
    out_d   = out_q;
    all_fin = 1'b1;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (start_acc || abort_acc) begin
        k_d[u]   = '0;
        out_d[u] = 1'b0;
      end else begin
        if (xfer[u]) out_d[u] = 1'b1;
        if (unit_done[u] && out_q[u]) begin
          out_d[u] = 1'b0;
          k_d[u]   = k_q[u] + KW'(1);
        end
      end
      all_fin = all_fin && (k_d[u] == K_L) && !out_d[u];
    end
  end

  // Completion is judged on next-cycle counters so FIN follows the last unit_done directly.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (all_fin) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      err_q    <= 1'b0;
      cycles_q <= '0;
      for (int u = 0; u < NUM_UNITS; u++) k_q[u] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      out_q   <= out_d;
      if (start_acc)      err_q <= |spurious;
      else if (|spurious) err_q <= 1'b1;
      if (start_acc)
        cycles_q <= '0;
      else if ((state_q == RUN) && (cycles_q != 32'hFFFF_FFFF))
        cycles_q <= cycles_q + 32'd1;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == FIN);
  assign err    = err_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_pim_tile_scheduler.sv
// Directed bench for pim_tile_scheduler: a scoreboard of expected jobs is checked
// against every observed transfer, alongside timing and status checks.
module tb_pim_tile_scheduler;

  localparam int NU  = 4;
  localparam int LEN = 10;

  logic            clk, rst, start, abort;
  logic            busy, done, err;
  logic [31:0]     cycles;
  logic [NU-1:0]   job_valid, job_ready, job_accum, unit_done;
  logic [NU*LEN-1:0] job_a_addr, job_b_addr, job_c_addr;
  logic [NU-1:0]   resp_done = '0;
  logic [NU-1:0]   spur_done;
  logic [NU-1:0]   pend;

  typedef struct {
    int unit;
    int a;
    int b;
    int c;
    int acc;
  } job_t;

  job_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  bit   stop = 0;

  assign unit_done = resp_done | spur_done;

  pim_tile_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .cycles(cycles),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a_addr(job_a_addr), .job_b_addr(job_b_addr), .job_c_addr(job_c_addr),
    .job_accum(job_accum), .unit_done(unit_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Unit model: completes each accepted job one cycle after the transfer.
  always begin
    @(negedge clk);
    pend = job_valid & job_ready;
    @(posedge clk);
    #1 resp_done = pend;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic job_t model(input int u, input int k);
    job_t j;
    int r, c;
    r = u / 2;
    c = u % 2;
    j.unit = u;
    j.a    = 0   + r*128 + k*8;
    j.b    = 256 + k*128 + c*8;
    j.c    = 512 + r*128 + c*8;
    j.acc  = (k != 0) ? 1 : 0;
    return j;
  endfunction

  task automatic push_jobs(input int kmax);
    for (int k = 0; k < kmax; k++)
      for (int u = 0; u < NU; u++) exp_q.push_back(model(u, k));
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int max, output int lat);
    lat = 0;
    for (int i = 1; i <= max && lat == 0; i++) begin
      tick();
      if (done) lat = i;
    end
  endtask

  task automatic monitor();
    while (!stop) begin
      @(negedge clk);
      if (done) done_cnt++;
      for (int u = 0; u < NU; u++) begin
        if (job_valid[u] && job_ready[u]) begin
          int idx;
          idx = -1;
          xfer_cnt++;
          for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].unit == u) idx = i;
          check("xfer_expected", (idx >= 0), 1);
          if (idx >= 0) begin
            check("sb_a_addr", 32'(job_a_addr[u*LEN +: LEN]), exp_q[idx].a);
            check("sb_b_addr", 32'(job_b_addr[u*LEN +: LEN]), exp_q[idx].b);
            check("sb_c_addr", 32'(job_c_addr[u*LEN +: LEN]), exp_q[idx].c);
            check("sb_accum", 32'(job_accum[u]), exp_q[idx].acc);
            exp_q.delete(idx);
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    int lat, d0, x0;

    // reset
    rst = 1; start = 0; abort = 0; job_ready = '0; spur_done = '0;
    tick(2);
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cycles", cycles, 0);
    check("rst_valid", job_valid, 0);
    check("rst_payload", |{job_a_addr, job_b_addr, job_c_addr, job_accum}, 0);

    // ideal run with address map spot checks
    job_ready = '1;
    push_jobs(2);
    d0 = done_cnt; x0 = xfer_cnt;
    pulse_start();
    check("ideal_busy_t1", busy, 1);
    check("ideal_valid_t1", job_valid, 4'hF);
    check("map_u1_a", job_a_addr[1*LEN +: LEN], 0);
    check("map_u1_b", job_b_addr[1*LEN +: LEN], 264);
    check("map_u1_c", job_c_addr[1*LEN +: LEN], 520);
    check("map_u1_acc", job_accum[1], 0);
    tick();
    check("ideal_valid_t2", job_valid, 0);
    tick();
    check("map_u3_valid", job_valid[3], 1);
    check("map_u3_a", job_a_addr[3*LEN +: LEN], 136);
    check("map_u3_b", job_b_addr[3*LEN +: LEN], 392);
    check("map_u3_c", job_c_addr[3*LEN +: LEN], 648);
    check("map_u3_acc", job_accum[3], 1);
    wait_done(12, lat);
    check("ideal_latency", lat + 3, 5);
    check("ideal_cycles", cycles, 4);
    check("ideal_busy_fin", busy, 0);
    tick(2);
    check("ideal_done_pulses", done_cnt - d0, 1);
    check("ideal_xfers", xfer_cnt - x0, 8);
    check("ideal_cycles_hold", cycles, 4);
    check("ideal_sb_empty", exp_q.size(), 0);

    // backpressure on unit 2
    job_ready = 4'b1011;
    push_jobs(2);
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      check("bp_u2_valid", job_valid[2], 1);
      check("bp_u2_a", job_a_addr[2*LEN +: LEN], 128);
      check("bp_u2_b", job_b_addr[2*LEN +: LEN], 256);
      check("bp_u2_c", job_c_addr[2*LEN +: LEN], 640);
      tick();
    end
    check("bp_no_early_done", done_cnt - d0, 0);
    check("bp_still_busy", busy, 1);
    job_ready = '1;
    wait_done(20, lat);
    check("bp_done_seen", (lat != 0), 1);
    tick();
    check("bp_done_pulses", done_cnt - d0, 1);
    check("bp_sb_empty", exp_q.size(), 0);

    // protocol errors
    spur_done = 4'b0001;
    tick();
    spur_done = '0;
    check("perr_err", err, 1);
    check("perr_busy", busy, 0);
    check("perr_valid", job_valid, 0);
    job_ready = '0;
    push_jobs(2);
    d0 = done_cnt;
    pulse_start();
    check("perr_err_cleared", err, 0);
    check("perr_busy_run", busy, 1);
    tick();
    pulse_start();
    check("perr_restart_valid", job_valid, 4'hF);
    check("perr_restart_accum", job_accum, 0);
    check("perr_restart_busy", busy, 1);
    job_ready = '1;
    tick(2);
    pulse_start();
    wait_done(20, lat);
    check("perr_done_seen", (lat != 0), 1);
    tick();
    check("perr_done_pulses", done_cnt - d0, 1);
    check("perr_sb_empty", exp_q.size(), 0);
    check("perr_err_final", err, 0);

    // abort after first transfer
    push_jobs(1);
    d0 = done_cnt;
    pulse_start();
    tick();
    abort = 1;
    tick();
    abort = 0;
    check("abort_valid", job_valid, 0);
    check("abort_busy", busy, 0);
    tick(4);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_err", err, 0);
    check("abort_sb_empty", exp_q.size(), 0);
    push_jobs(2);
    pulse_start();
    check("restart_valid", job_valid, 4'hF);
    check("restart_accum", job_accum, 0);
    wait_done(12, lat);
    check("restart_latency", lat, 4);
    tick();
    check("restart_sb_empty", exp_q.size(), 0);

    // reset mid-run
    job_ready = '0;
    d0 = done_cnt;
    pulse_start();
    tick();
    rst = 1;
    tick(2);
    rst = 0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_cycles", cycles, 0);
    check("mrst_valid", job_valid, 0);
    check("mrst_payload", |{job_a_addr, job_b_addr, job_c_addr, job_accum}, 0);
    tick(2);
    check("mrst_no_done", done_cnt - d0, 0);
    check("mrst_still_idle", busy, 0);

    stop = 1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
